note_player: RTL
================

Name: note_player

Overview:
- Playback end of the note-entry path. Accepts one (octave, note, length) triple per valid/ready handshake.
- Drives a square-wave buzzer at the note's pitch for the note's duration, ending with a short silent articulation gap.
- Sits between the note-capture / score-sequencing logic and the buzzer pin. Reports busy and a one-cycle done pulse per note.

Parameters:
- OCTAVE_BITS, 2, octave field width (octave 0 = C3..B3 base octave; each step up halves the period)
- NOTE_BITS, 3, note field width (0..6 = C D E F G A B, 7 = rest)
- LENGTH_BITS, 3, length code width (0..6 valid; 7 is treated as 6)
- UNIT_CYCLES, 3125000, clock cycles for length code 0 (1/32 s at 100 MHz)
- GAP_CYCLES, 250000, silent cycles at the end of every note
- SIM_SHIFT, 0, extra right shift on the pitch table, for simulation only

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- en  in  1  play enable; low aborts the current note and forces IDLE
- in_valid  in  1  note triple valid
- in_ready  out  1  player can accept a note
- octave  in  OCTAVE_BITS  octave of the note
- note  in  NOTE_BITS  note index (7 = rest)
- length  in  LENGTH_BITS  duration code
- buzzer  out  1  square-wave tone output
- busy  out  1  high while in TONE or GAP
- done  out  1  one-cycle pulse on normal note completion

Behaviour:
- Reset (async, rst=1): state IDLE, buzzer=0, busy=0, done=0, in_ready=1 (if en=1), all counters and latches cleared.
- in_ready = en && (state==IDLE).
- Accept on a rising edge with in_valid && in_ready. On accept, latch octave, note and length. Inputs are ignored at all other times.
- Pitch table (half-period cycles at 100 MHz, octave 0): C 382234, D 340530, E 303380, F 286353, G 255102, A 227273, B 202478.
- Half-period: half = TABLE[note] >> (octave + SIM_SHIFT), computed at accept. If the result is 0, clamp it to 1.
- Duration: total = UNIT_CYCLES << min(length,6), using a 32-bit counter.
  - tone_len = total - GAP_CYCLES.
  - If total <= GAP_CYCLES, tone_len = 0 and the whole note is silent gap.
- FSM states:
  - IDLE --accept--> TONE if tone_len > 0, else GAP.
  - TONE: lasts exactly tone_len cycles, then GAP.
  - GAP: lasts exactly min(GAP_CYCLES, total) cycles, then IDLE with done=1 for that first IDLE cycle.
- Timing: a note accepted at edge k occupies TONE+GAP for exactly `total` cycles, starting at cycle k+1. busy is high for exactly those cycles.
- Tone generation:
  - On entry to TONE, buzzer=0 and the phase counter is 0.
  - The phase counter increments each cycle. When it reaches half-1, it wraps to 0 and buzzer toggles.
  - Result: the first toggle occurs after `half` cycles in TONE.
- Rests: note==7 keeps buzzer=0 for the whole duration. Timing, busy and done are unchanged.
- Gap and idle: buzzer=0 in GAP and IDLE.
- Back-to-back: in the done cycle in_ready=1, so a note presented then is accepted with no idle bubble beyond that one cycle.
- en low in any state:
  - Next edge: state=IDLE, buzzer=0, busy=0, done=0, in_ready=0.
  - The aborted note produces no done.
  - Playback resumes only after en returns high and a fresh handshake occurs.
- rst mid-note: immediate return to the reset values; no done.
- in_valid held while busy: no effect. The latched note is unaffected by input changes.

Test Plan:
- Reset: assert rst with en=1 -> buzzer=0, busy=0, done=0, in_ready=1; hold for 5 cycles, no change.
- Play A (note 5), octave 0, length 0 with UNIT_CYCLES=8, GAP_CYCLES=2, SIM_SHIFT=16 (half=3):
  - busy for 8 cycles; buzzer = 0,0,0,1,1,1 then gap 0,0.
  - done pulses exactly once in the following cycle; in_ready high again.
- Rest (note 7), length 2, same parameters -> busy for 32 cycles, buzzer constant 0, single done pulse.
- C (note 0), octave 1, same parameters (half = 382234>>17 = 2), length 1 -> 14 tone cycles with buzzer = 0,0,1,1,0,0,..., then 2 gap cycles, done.
- Drop en at the 3rd tone cycle -> next cycle state IDLE, buzzer=0, busy=0, in_ready=0, no done; re-raise en -> in_ready=1.
- Hold in_valid=1 with changing note values during a length-0 note -> no acceptance while busy; the next note is accepted in the done cycle, busy resumes the following cycle, and the first note's buzzer pattern is unaltered.

Source files
------------

// File: rtl/note_player.sv
// Square-wave note player: takes one (octave, note, length) triple per handshake and
// drives the buzzer at the note's pitch, finishing every note with a silent gap.
module note_player #(
   parameter int OCTAVE_BITS = 2,
   parameter int NOTE_BITS   = 3,
   parameter int LENGTH_BITS = 3,
   parameter int UNIT_CYCLES = 3125000,
   parameter int GAP_CYCLES  = 250000,
   parameter int SIM_SHIFT   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [OCTAVE_BITS-1:0] octave,
   input  logic [NOTE_BITS-1:0]   note,
   input  logic [LENGTH_BITS-1:0] length,
   output logic                   buzzer,
   output logic                   busy,
   output logic                   done
);

   localparam logic [31:0] UNIT = 32'(UNIT_CYCLES);
   localparam logic [31:0] GAP  = 32'(GAP_CYCLES);

   typedef enum logic [1:0] {IDLE = 2'd0, TONE = 2'd1, GAP_ST = 2'd2} state_t;

   state_t state, next_state;

   // Handshake: a note is taken on a rising edge where in_valid && in_ready;
   // in_ready is high only while enabled and idle, nothing else is sampled.
   logic accept;

   logic [31:0] cnt;
   logic [31:0] phase;
   logic [31:0] half_q, tone_len_q, gap_len_q;
   logic        rest_q;

   logic [31:0] len_sel, total_c, half_raw, half_c, tone_len_c, gap_len_c;
   logic        rest_c;
   logic        tone_last, gap_last, finish;

   // Half-period in cycles for octave 0.
   function automatic logic [31:0] pitch(input logic [NOTE_BITS-1:0] n);
      logic [31:0] v;
      case (32'(n))
         0:       v = 32'd382234;
         1:       v = 32'd340530;
         2:       v = 32'd303380;
         3:       v = 32'd286353;
         4:       v = 32'd255102;
         5:       v = 32'd227273;
         6:       v = 32'd202478;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   always_comb begin
      len_sel    = (32'(length) > 32'd6) ? 32'd6 : 32'(length);
      total_c    = UNIT << len_sel;
      half_raw   = pitch(note) >> (32'(octave) + 32'(SIM_SHIFT));
      half_c     = (half_raw == 32'd0) ? 32'd1 : half_raw;
      tone_len_c = (total_c > GAP) ? total_c - GAP : 32'd0;
      gap_len_c  = (total_c < GAP) ? total_c : GAP;
      rest_c     = (32'(note) == 32'd7);
   end

   assign accept    = in_valid && in_ready;
   assign tone_last = (cnt == tone_len_q - 32'd1);
   assign gap_last  = (cnt == gap_len_q - 32'd1);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      finish     = 1'b0;
      if (!en) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:   if (accept) next_state = (tone_len_c != 32'd0) ? TONE : GAP_ST;
            TONE:   if (tone_last) begin
                       next_state = (gap_len_q == 32'd0) ? IDLE : GAP_ST;
                       finish     = (gap_len_q == 32'd0);
                    end
            GAP_ST: if (gap_last) begin
                       next_state = IDLE;
                       finish     = 1'b1;
                    end
            default: next_state = IDLE;
         endcase
      end
   end

   // Outputs decoded from state
   always_comb begin
      busy     = (state != IDLE);
      in_ready = en && (state == IDLE);
   end

   // Datapath: note latches, duration counter, tone phase and done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         phase      <= '0;
         half_q     <= '0;
         tone_len_q <= '0;
         gap_len_q  <= '0;
         rest_q     <= 1'b0;
         buzzer     <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            half_q     <= half_c;
            tone_len_q <= tone_len_c;
            gap_len_q  <= gap_len_c;
            rest_q     <= rest_c;
         end
         if (next_state != state || state == IDLE) cnt <= '0;
         else                                      cnt <= cnt + 32'd1;
         // Tone toggles only while staying in TONE; any entry or exit restarts at 0.
         if (state == TONE && next_state == TONE) begin
            if (phase == half_q - 32'd1) begin
               phase  <= '0;
               buzzer <= buzzer ^ ~rest_q;
            end else begin
               phase <= phase + 32'd1;
            end
         end else begin
            phase  <= '0;
            buzzer <= 1'b0;
         end
      end
   end

endmodule
